// File: rtl/div_share_arbiter.sv
// Time-shares one iterative divider core between NREQ requesters.
// A round-robin grant picks a requester in IDLE; its operands are latched and
// held on the core inputs while the core runs. The result (or a divide-by-zero
// or timeout error) comes back over a per-requester valid/ready handshake.
module div_share_arbiter #(
   parameter int WIDTH   = 16,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_dividend,
   input  logic [NREQ*WIDTH-1:0] req_divisor,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_quotient,
   output logic [WIDTH-1:0]      rsp_remainder,
   output logic                  rsp_err,
   output logic                  div_start,
   output logic [WIDTH-1:0]      div_dividend,
   output logic [WIDTH-1:0]      div_divisor,
   input  logic [WIDTH-1:0]      div_quotient,
   input  logic [WIDTH-1:0]      div_remainder,
   input  logic                  div_done
);

   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

   stateT            state;
   stateT            nextState;
   logic [IDXW-1:0]  gntIdx;
   logic [IDXW-1:0]  rrPtr;
   logic [WIDTH-1:0] opDividend;
   logic [WIDTH-1:0] opDivisor;
   logic [WIDTH-1:0] resQuot;
   logic [WIDTH-1:0] resRem;
   logic             resErr;
   logic [TW-1:0]    timer;
   logic             timerExpired;
   logic             grantFound;
   logic [IDXW-1:0]  grantSel;
   logic [IDXW:0]    probe;
   logic [WIDTH-1:0] dividendArr [NREQ];
   logic [WIDTH-1:0] divisorArr  [NREQ];
   logic [WIDTH-1:0] selDividend;
   logic [WIDTH-1:0] selDivisor;

   // Unpack the flat operand buses so the granted requester can be selected by index.
   for (genvar g = 0; g < NREQ; g++) begin : gUnpack
      assign dividendArr[g] = req_dividend[g*WIDTH +: WIDTH];
      assign divisorArr[g]  = req_divisor[g*WIDTH +: WIDTH];
   end

   assign selDividend  = dividendArr[grantSel];
   assign selDivisor   = divisorArr[grantSel];
   assign timerExpired = (timer == TW'(TIMEOUT - 1));

   assign div_dividend  = opDividend;
   assign div_divisor   = opDivisor;
   assign rsp_quotient  = resQuot;
   assign rsp_remainder = resRem;
   assign rsp_err       = resErr;

   // Round-robin search: the first valid requester at or after rrPtr, wrapping modulo NREQ.
   always_comb begin
      grantFound = 1'b0;
      grantSel   = '0;
      probe      = '0;
      for (int k = 0; k < NREQ; k++) begin
         probe = {1'b0, rrPtr} + (IDXW+1)'(k);
         if (probe >= (IDXW+1)'(NREQ)) begin
            probe = probe - (IDXW+1)'(NREQ);
         end
         if (!grantFound && req_valid[probe[IDXW-1:0]]) begin
            grantFound = 1'b1;
            grantSel   = probe[IDXW-1:0];
         end
      end
   end

   // State register; reset drops any in-flight transaction without a response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and handshake outputs; req_ready is only ever raised in IDLE and never during reset.
   always_comb begin
      nextState = state;
      req_ready = '0;
      rsp_valid = '0;
      div_start = 1'b0;
      case (state)
         IDLE: begin
            if (grantFound && !rst) begin
               req_ready[grantSel] = 1'b1;
               nextState = (selDivisor == '0) ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            div_start = 1'b1;
            nextState = WAIT;
         end
         WAIT: begin
            if (div_done || timerExpired) begin
               nextState = RESP;
            end
         end
         RESP: begin
            rsp_valid[gntIdx] = 1'b1;
            if (rsp_ready[gntIdx]) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath: latch operands on accept, run the watchdog in WAIT, capture results
   // (done wins over a same-cycle timeout), and advance the round-robin pointer on handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gntIdx     <= '0;
         rrPtr      <= '0;
         opDividend <= '0;
         opDivisor  <= '0;
         resQuot    <= '0;
         resRem     <= '0;
         resErr     <= 1'b0;
         timer      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grantFound) begin
                  gntIdx     <= grantSel;
                  opDividend <= selDividend;
                  opDivisor  <= selDivisor;
                  if (selDivisor == '0) begin
                     resQuot <= '1;
                     resRem  <= selDividend;
                     resErr  <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               timer <= '0;
            end
            WAIT: begin
               timer <= timer + 1'b1;
               if (div_done) begin
                  resQuot <= div_quotient;
                  resRem  <= div_remainder;
                  resErr  <= 1'b0;
               end else if (timerExpired) begin
                  resQuot <= '0;
                  resRem  <= '0;
                  resErr  <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready[gntIdx]) begin
                  rrPtr <= (gntIdx == IDXW'(NREQ - 1)) ? '0 : gntIdx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/div_share_arbiter.md
# div_share_arbiter

Shares one iterative divider core between `NREQ` independent requesters. The arbiter runs a round-robin arbiter, issues a single-cycle start pulse to the divider, and holds the operands stable while the divider runs. It then routes the quotient and remainder back to the granted requester over a valid/ready response handshake. It also short-circuits divide-by-zero and bounds each divide with a watchdog. The block sits between the client blocks and the divider core, and it is the only driver of the core's `start`, `dividend` and `divisor` inputs.

## Interface
- `WIDTH`, 16: operand and result width; must match the divider core.
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: maximum number of cycles to wait for divider done; ≥ 8.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_ready`  out  NREQ: per-requester accept; one-hot or zero.
- `req_dividend`  in  NREQ*WIDTH: packed; requester i uses bits [i*WIDTH +: WIDTH].
- `req_divisor`  in  NREQ*WIDTH: packed, same layout as `req_dividend`.
- `rsp_valid`  out  NREQ: per-requester response valid; one-hot or zero.
- `rsp_ready`  in  NREQ: per-requester response accept.
- `rsp_quotient`  out  WIDTH: shared response bus; meaningful only while any `rsp_valid` bit is high.
- `rsp_remainder`  out  WIDTH: shared response bus.
- `rsp_err`  out  1: 1 means divide-by-zero or timeout.
- `div_start`  out  1: one-cycle start pulse to the divider core.
- `div_dividend`, `div_divisor`  out  WIDTH each: operands to the core; held stable from ISSUE to the end of WAIT.
- `div_quotient`, `div_remainder`  in  WIDTH each: results from the core.
- `div_done`  in  1: core done; sampled only in WAIT.

## Operation
- The FSM states are IDLE, ISSUE, WAIT and RESP. Registers:
  - `gnt_idx` (clog2 NREQ bits)
  - `rr_ptr`
  - operand registers
  - result registers
  - `timer`, wide enough to count to TIMEOUT
- **IDLE**
  - Grant goes to the first i with `req_valid[i]`=1, searching i = `rr_ptr`, `rr_ptr`+1, … modulo NREQ.
  - `req_ready[g]` is asserted combinationally in the same cycle. A combinational path from `req_valid` to `req_ready` exists in IDLE only.
  - On accept, latch dividend, divisor and g into `gnt_idx`.
  - If the latched divisor is 0: go to RESP with quotient = all ones, remainder = dividend, err = 1. The core is not started.
  - Otherwise go to ISSUE.
  - With no valid requests, stay in IDLE and drive `req_ready` = 0.
- **ISSUE**: `div_start` = 1 for exactly one cycle, then go to WAIT with `timer` cleared.
- **WAIT**
  - `timer` increments every cycle.
  - When `div_done` = 1: capture `div_quotient` and `div_remainder`, set err = 0, go to RESP.
  - When `timer` = TIMEOUT−1 with no done: quotient = 0, remainder = 0, err = 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- **RESP**
  - `rsp_valid[gnt_idx]` = 1 and the result registers drive the buses.
  - Hold all of these stable until `rsp_ready[gnt_idx]` = 1.
  - On that handshake: `rr_ptr` ← (`gnt_idx`+1) mod NREQ, go to IDLE.
  - `rsp_ready` bits of non-granted requesters are ignored.
- Only one divide is outstanding at a time. `req_ready` is 0 in every state except IDLE.
- `div_done` outside WAIT is ignored, including a late done that arrives after a timeout.
- A requester may not withdraw `req_valid` before accept. If it does, the grant re-evaluates in that cycle with no side effects.
- `div_dividend` and `div_divisor` are driven from the operand registers in all states.

## Timing
- **Reset** (asynchronous assert, synchronous deassert at the design level):
  - state = IDLE, `rr_ptr` = 0, `gnt_idx` = 0, `timer` = 0.
  - All outputs are 0: `req_ready`, `rsp_valid`, `rsp_quotient`, `rsp_remainder`, `rsp_err`, `div_start`, `div_dividend`, `div_divisor`.
- **Reset during WAIT or RESP**: the transaction is dropped with no response. The divider core has its own reset and is not flushed by this block.
- **Accept latency**: `req_valid` high in IDLE gives accept in the same cycle. `div_start` goes high on the next cycle (ISSUE).
- **Total latency**, accept edge to `rsp_valid`: 2 + D cycles, where D is the number of cycles from `div_start` to `div_done`.
- **Divide-by-zero**: `rsp_valid` in the cycle after accept.
- **Timeout**: `rsp_valid` TIMEOUT+2 cycles after accept.
- **Back-to-back**: after the response handshake there is 1 cycle in IDLE before the next accept. A handshake in RESP and an accept in IDLE never occur in the same cycle.

## Test plan
- **Single divide**: requester 1 sends 100 / 7; core model with D = 10. Required: `req_ready[1]` in the accept cycle, one `div_start` pulse, `rsp_valid[1]` with q = 14, r = 2, err = 0 exactly 12 cycles after accept.
- **Round-robin**: all four requesters assert valid from reset with distinct operands. Required grant order 0, 1, 2, 3, 0. Each response is routed to the correct index with correct values (for example 65535 / 255 gives q = 257, r = 0).
- **Divide-by-zero**: requester 2 sends 1234 / 0. Required: no `div_start`; `rsp_valid[2]` on the next cycle with q = 16'hFFFF, r = 1234, err = 1.
- **Timeout**: core model never asserts done. Required: `rsp_valid` at accept + 66 cycles with q = 0, r = 0, err = 1. A late `div_done` injected afterwards is ignored.
- **Backpressure**: hold `rsp_ready` low for 5 cycles during RESP while another requester is valid. Required: response buses stable, `req_ready` = 0 throughout; the new accept happens exactly 1 cycle after the handshake.
- **Mid-operation reset**: assert `rst` during WAIT. Required: all outputs 0 asynchronously, state IDLE, `rr_ptr` = 0. After reset release, a new 50 / 5 request returns q = 10, r = 0.
